// File: rtl/bcd_display_formatter.sv
// Binary-to-BCD formatter for the 4-digit seven-segment driver: sequential double-dabble,
// one bit per clk5 edge, with a held display word and decimal-point enables.
`timescale 1ns/1ps
module bcd_display_formatter #(
   parameter int IN_W   = 14,
   parameter int MAXVAL = 9999
) (
   input  logic            clk5,
   input  logic            reset,
   input  logic [IN_W-1:0] binIn,
   input  logic            load,
   input  logic            dpEn,
   input  logic [1:0]      dpPos,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   output logic [15:0]     dispVal,
   output logic [3:0]      point
);

   // Handshake: load is a request that is accepted on any edge where busy is low
   // (IDLE, including the cycle in which done is high); while busy is high load is
   // ignored, never queued. done is a single-cycle pulse marking new dispVal/point.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      UPD  = 2'd2
   } state_t;

   localparam logic [IN_W-1:0] MAX_BIN  = IN_W'(MAXVAL);
   localparam logic [3:0]      LAST_ITR = 4'(IN_W - 1);

   state_t          state;
   logic [IN_W-1:0] binSh;
   logic [15:0]     bcd;
   logic [3:0]      itr;
   logic            dpEnQ;
   logic [1:0]      dpPosQ;
   logic            ovfPend;

   logic [15:0]     bcdAdj;
   logic [IN_W-1:0] binClamp;

   // All four nibbles are corrected from the same pre-shift value.
   always_comb begin
      bcdAdj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      binClamp = (binIn > MAX_BIN) ? MAX_BIN : binIn;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk5) begin
      if (reset) begin
         state    <= IDLE;
         binSh    <= '0;
         bcd      <= '0;
         itr      <= '0;
         dpEnQ    <= 1'b0;
         dpPosQ   <= '0;
         ovfPend  <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         dispVal  <= '0;
         point    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  binSh   <= binClamp;
                  ovfPend <= (binIn > MAX_BIN);
                  dpEnQ   <= dpEn;
                  dpPosQ  <= dpPos;
                  bcd     <= '0;
                  itr     <= '0;
                  state   <= CONV;
               end
            end
            CONV: begin
               bcd   <= {bcdAdj[14:0], binSh[IN_W-1]};
               binSh <= {binSh[IN_W-2:0], 1'b0};
               itr   <= itr + 4'd1;
               if (itr == LAST_ITR) begin
                  state <= UPD;
               end
            end
            UPD: begin
               dispVal  <= bcd;
               overflow <= ovfPend;
               if (ovfPend) begin
                  point <= 4'b1111;
               end else if (dpEnQ) begin
                  point <= 4'b0001 << dpPosQ;
               end else begin
                  point <= 4'b0000;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter: conversion results, clamp, decimal point,
// handshake corner cases and mid-conversion reset, all against hand-computed values.
`timescale 1ns/1ps
module tb_bcd_display_formatter;

   logic        clk5 = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] binIn = '0;
   logic        load = 1'b0;
   logic        dpEn = 1'b0;
   logic [1:0]  dpPos = '0;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [15:0] dispVal;
   logic [3:0]  point;

   int checks = 0;
   int errors = 0;

   bcd_display_formatter dut (
      .clk5     (clk5),
      .reset    (reset),
      .binIn    (binIn),
      .load     (load),
      .dpEn     (dpEn),
      .dpPos    (dpPos),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .dispVal  (dispVal),
      .point    (point)
   );

   always #100 clk5 = ~clk5;

   // Driver: one load, inputs scrambled right after acceptance, then waits for done.
   task automatic run_conv(input logic [13:0] val, input logic de, input logic [1:0] dp,
                           output int lat, output int bcnt, output logic dnext);
      @(negedge clk5);
      binIn = val; dpEn = de; dpPos = dp; load = 1'b1;
      @(negedge clk5);
      load = 1'b0; binIn = 14'h3FFF ^ val; dpEn = ~de; dpPos = dp + 2'd1;
      lat = -1; bcnt = 0;
      for (int n = 0; n <= 40; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk5);
      end
      @(negedge clk5);
      dnext = done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk5);
      checks++; if (dispVal !== 16'h0000) begin errors++; $display("FAIL reset_dispval got %h exp 0000", dispVal); end
      checks++; if (point !== 4'b0000) begin errors++; $display("FAIL reset_point got %b exp 0000", point); end
      checks++; if ({busy, done, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, overflow}); end
      reset = 1'b0;
      @(negedge clk5);
   endtask

   task automatic test_basic();
      int lat, bcnt; logic dn;
      run_conv(14'd1234, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency got %0d exp 15", lat); end
      checks++; if (bcnt !== 15) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 15", bcnt); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", dn); end
      checks++; if (dispVal !== 16'h1234) begin errors++; $display("FAIL basic_dispval got %h exp 1234", dispVal); end
      checks++; if ({overflow, point} !== 5'b0_0000) begin errors++; $display("FAIL basic_ovf_point got %b exp 00000", {overflow, point}); end
   endtask

   task automatic test_boundaries();
      int lat, bcnt; logic dn;
      run_conv(14'd0, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h0000) begin errors++; $display("FAIL zero_dispval got %h exp 0000", dispVal); end
      checks++; if (lat !== 15) begin errors++; $display("FAIL zero_latency got %0d exp 15", lat); end
      run_conv(14'd9999, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h9999) begin errors++; $display("FAIL max_dispval got %h exp 9999", dispVal); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL max_overflow got %b exp 0", overflow); end
      run_conv(14'd5070, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h5070) begin errors++; $display("FAIL mixed_dispval got %h exp 5070", dispVal); end
   endtask

   task automatic test_clamp();
      int lat, bcnt; logic dn;
      run_conv(14'd12000, 1'b1, 2'd1, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h9999) begin errors++; $display("FAIL clamp_dispval got %h exp 9999", dispVal); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clamp_overflow got %b exp 1", overflow); end
      checks++; if (point !== 4'b1111) begin errors++; $display("FAIL clamp_point got %b exp 1111", point); end
      run_conv(14'd10000, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if ({overflow, dispVal} !== {1'b1, 16'h9999}) begin errors++; $display("FAIL clamp_edge got %b_%h exp 1_9999", overflow, dispVal); end
      run_conv(14'd5, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h0005) begin errors++; $display("FAIL post_clamp_dispval got %h exp 0005", dispVal); end
      checks++; if ({overflow, point} !== 5'b0_0000) begin errors++; $display("FAIL post_clamp_flags got %b exp 00000", {overflow, point}); end
   endtask

   task automatic test_decimal_point();
      int lat, bcnt; logic dn;
      run_conv(14'd3140, 1'b1, 2'd2, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h3140) begin errors++; $display("FAIL dp_dispval got %h exp 3140", dispVal); end
      checks++; if (point !== 4'b0100) begin errors++; $display("FAIL dp_pos2 got %b exp 0100", point); end
      run_conv(14'd3140, 1'b0, 2'd2, lat, bcnt, dn);
      checks++; if (point !== 4'b0000) begin errors++; $display("FAIL dp_off got %b exp 0000", point); end
      run_conv(14'd7, 1'b1, 2'd0, lat, bcnt, dn);
      checks++; if (point !== 4'b0001) begin errors++; $display("FAIL dp_pos0 got %b exp 0001", point); end
      run_conv(14'd7, 1'b1, 2'd3, lat, bcnt, dn);
      checks++; if (point !== 4'b1000) begin errors++; $display("FAIL dp_pos3 got %b exp 1000", point); end
   endtask

   task automatic test_load_while_busy();
      int lat; int busy_seen;
      @(negedge clk5);
      binIn = 14'd42; dpEn = 1'b0; load = 1'b1;
      @(negedge clk5);
      load = 1'b0;
      repeat (5) @(negedge clk5);
      binIn = 14'd777; load = 1'b1;
      @(negedge clk5);
      load = 1'b0;
      lat = -1;
      for (int n = 6; n <= 40; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(negedge clk5);
      end
      checks++; if (lat !== 15) begin errors++; $display("FAIL ignore_latency got %0d exp 15", lat); end
      checks++; if (dispVal !== 16'h0042) begin errors++; $display("FAIL ignore_dispval got %h exp 0042", dispVal); end
      busy_seen = 0;
      repeat (4) begin
         @(negedge clk5);
         if (busy || done) busy_seen++;
      end
      checks++; if (busy_seen !== 0) begin errors++; $display("FAIL ignore_no_restart got %0d exp 0", busy_seen); end
   endtask

   task automatic test_back_to_back();
      int t, t1, t2, t3;
      @(negedge clk5);
      binIn = 14'd100; dpEn = 1'b0; load = 1'b1;
      t = 0; t1 = -1; t2 = -1; t3 = -1;
      while (t < 80 && t3 < 0) begin
         @(negedge clk5);
         t++;
         if (done) begin
            if (t1 < 0) t1 = t;
            else if (t2 < 0) t2 = t;
            else t3 = t;
         end
      end
      load = 1'b0;
      checks++; if (t1 !== 16) begin errors++; $display("FAIL b2b_first got %0d exp 16", t1); end
      checks++; if (t2 - t1 !== 16) begin errors++; $display("FAIL b2b_period1 got %0d exp 16", t2 - t1); end
      checks++; if (t3 - t2 !== 16) begin errors++; $display("FAIL b2b_period2 got %0d exp 16", t3 - t2); end
      checks++; if (dispVal !== 16'h0100) begin errors++; $display("FAIL b2b_dispval got %h exp 0100", dispVal); end
      @(negedge clk5);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy %b exp 0", busy); end
   endtask

   task automatic test_reset_mid_conv();
      int lat, bcnt, seen; logic dn;
      run_conv(14'd42, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (dispVal !== 16'h0042) begin errors++; $display("FAIL pre_reset_dispval got %h exp 0042", dispVal); end
      @(negedge clk5);
      binIn = 14'd8888; load = 1'b1;
      @(negedge clk5);
      load = 1'b0;
      repeat (6) @(negedge clk5);
      reset = 1'b1;
      @(negedge clk5);
      reset = 1'b0;
      checks++; if (dispVal !== 16'h0000) begin errors++; $display("FAIL midreset_dispval got %h exp 0000", dispVal); end
      checks++; if ({busy, done, overflow, point} !== 7'b0) begin errors++; $display("FAIL midreset_flags got %b exp 0000000", {busy, done, overflow, point}); end
      seen = 0;
      repeat (20) begin
         @(negedge clk5);
         if (done || busy) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_quiet got %0d exp 0", seen); end
      run_conv(14'd55, 1'b0, 2'd0, lat, bcnt, dn);
      checks++; if (lat !== 15) begin errors++; $display("FAIL after_reset_latency got %0d exp 15", lat); end
      checks++; if (dispVal !== 16'h0055) begin errors++; $display("FAIL after_reset_dispval got %h exp 0055", dispVal); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_clamp();
      test_decimal_point();
      test_load_while_busy();
      test_back_to_back();
      test_reset_mid_conv();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
